// File: rtl/uram_burst_read_counter.sv
// Burst read address generator for a circular URAM buffer.
// Each accepted request (start address, length) is turned into a contiguous
// run of read addresses that wraps at DEPTH. A one-entry pending slot lets the
// next burst follow the current one with no idle cycle in between.
module uram_burst_read_counter #(
    parameter int ADDR_BITS = 14,
    parameter int DEPTH     = 16384,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 run_i,
    input  logic [ADDR_BITS-1:0] start_addr_i,
    input  logic [LEN_BITS-1:0]  len_i,
    input  logic                 abort_i,
    output logic                 ready_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 addr_valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2^ADDR_BITS is representable for the range check.
    localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
    localparam logic [LEN_BITS:0]    FULL_LEN  = {1'b1, {LEN_BITS{1'b0}}};
    localparam logic [LEN_BITS:0]    ONE_LEN   = (LEN_BITS + 1)'(1'b1);
    localparam logic [LEN_BITS:0]    TWO_LEN   = (LEN_BITS + 1)'(2'd2);

    // Length field 0 means a full 2^LEN_BITS burst.
    function automatic logic [LEN_BITS:0] burst_len(input logic [LEN_BITS-1:0] len);
        burst_len = (len == {LEN_BITS{1'b0}}) ? FULL_LEN : {1'b0, len};
    endfunction

    // Circular increment; DEPTH need not be a power of two.
    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
        next_addr = (a == LAST_ADDR) ? {ADDR_BITS{1'b0}} : a + ADDR_BITS'(1'b1);
    endfunction

    state_t                state_r, state_s;
    logic [ADDR_BITS-1:0]  addr_r, addr_s;
    logic [LEN_BITS:0]     rem_r, rem_s;
    logic                  valid_r, valid_s;
    logic                  last_r, last_s;
    logic                  busy_r, busy_s;
    logic                  err_r, err_s;
    logic                  pend_r, pend_s;
    logic [ADDR_BITS-1:0]  pend_addr_r, pend_addr_s;
    logic [LEN_BITS-1:0]   pend_len_r, pend_len_s;
    logic                  acc_s;
    logic                  bad_s;
    logic                  go_s;

    assign ready_o = !pend_r && !abort_i;
    assign acc_s   = run_i && ready_o;
    assign bad_s   = ({1'b0, start_addr_i} >= DEPTH_W);
    assign go_s    = acc_s && !bad_s;

    // Next-state, address/length counter and pending-slot control.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        rem_s       = rem_r;
        valid_s     = 1'b0;
        last_s      = 1'b0;
        pend_s      = pend_r;
        pend_addr_s = pend_addr_r;
        pend_len_s  = pend_len_r;
        err_s       = acc_s && bad_s;
        if (abort_i) begin
            state_s = IDLE;
            pend_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        state_s = RUN;
                        addr_s  = start_addr_i;
                        rem_s   = burst_len(len_i);
                        valid_s = 1'b1;
                        last_s  = (burst_len(len_i) == ONE_LEN);
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (last_r) begin
                        if (pend_r) begin
                            // Chain the stored burst directly behind the finished one.
                            state_s = RUN;
                            addr_s  = pend_addr_r;
                            rem_s   = burst_len(pend_len_r);
                            valid_s = 1'b1;
                            last_s  = (burst_len(pend_len_r) == ONE_LEN);
                            pend_s  = 1'b0;
                        end else if (go_s) begin
                            state_s = RUN;
                            addr_s  = start_addr_i;
                            rem_s   = burst_len(len_i);
                            valid_s = 1'b1;
                            last_s  = (burst_len(len_i) == ONE_LEN);
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        addr_s  = next_addr(addr_r);
                        rem_s   = rem_r - ONE_LEN;
                        valid_s = 1'b1;
                        last_s  = (rem_r == TWO_LEN);
                        if (go_s) begin
                            pend_s      = 1'b1;
                            pend_addr_s = start_addr_i;
                            pend_len_s  = len_i;
                        end else begin
                            pend_s = pend_r;
                        end
                    end
                end
                default: begin
                    state_s = IDLE;
                    pend_s  = 1'b0;
                end
            endcase
        end
        busy_s = (state_s == RUN) || pend_s;
    end

    // State and registered outputs, cleared asynchronously by rstn_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_BITS{1'b0}};
            rem_r       <= {(LEN_BITS + 1){1'b0}};
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            pend_r      <= 1'b0;
            pend_addr_r <= {ADDR_BITS{1'b0}};
            pend_len_r  <= {LEN_BITS{1'b0}};
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            rem_r       <= rem_s;
            valid_r     <= valid_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
            pend_r      <= pend_s;
            pend_addr_r <= pend_addr_s;
            pend_len_r  <= pend_len_s;
        end
    end

    assign addr_o       = addr_r;
    assign addr_valid_o = valid_r;
    assign last_o       = last_r;
    assign busy_o       = busy_r;
    assign err_o        = err_r;

endmodule

// File: doc/uram_burst_read_counter.md
URAM_BURST_READ_COUNTER -- requirements
Module: uram_burst_read_counter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14, URAM read address width.
REQ-002 SHALL have parameter DEPTH, default 16384, circular buffer depth in words (2..2^ADDR_BITS, need not be a power of two).
REQ-003 SHALL have parameter LEN_BITS, default 8, burst length field width.
REQ-004 SHALL have ports clk_i (in, 1, sole clock) and rstn_i (in, 1, asynchronous active-low reset): one clock; reset asynchronous, active-low.
REQ-005 SHALL have port run_i, in, 1: burst request strobe.
REQ-006 SHALL have port start_addr_i, in, ADDR_BITS: first address of the burst.
REQ-007 SHALL have port len_i, in, LEN_BITS: burst length; 0 encodes 2^LEN_BITS.
REQ-008 SHALL have port abort_i, in, 1: flush the active and pending bursts.
REQ-009 SHALL have port ready_o, out, 1: pending slot free, so a request can be accepted.
REQ-010 SHALL have ports addr_o (out, ADDR_BITS, read address) and addr_valid_o (out, 1, addr_o valid this cycle).
REQ-011 SHALL have ports last_o (out, 1, final address of burst), busy_o (out, 1, burst active or pending) and err_o (out, 1, rejected-request pulse).

Function
REQ-012 SHALL accept a request on a rising edge where run_i && ready_o && !abort_i; ready_o SHALL be combinationally low while abort_i is high.
REQ-013 SHALL reject an accepted-condition request with start_addr_i >= DEPTH: no addresses emitted, err_o high for exactly the next cycle.
REQ-014 SHALL, when idle, present the first address on addr_o with addr_valid_o high in the cycle after acceptance (latency 1).
REQ-015 SHALL emit exactly N consecutive valid addresses per burst (N = len_i, or 2^LEN_BITS if len_i == 0), with no gaps.
REQ-016 SHALL increment the address by 1 per valid cycle; DEPTH-1 SHALL wrap to 0.
REQ-017 SHALL assert last_o together with addr_valid_o on the Nth address only; an N=1 burst SHALL assert last_o on its only address.
REQ-018 SHALL hold a one-entry pending slot: a request accepted while a burst is active is stored, and ready_o drops until that slot is consumed.
REQ-019 SHALL start the pending burst in the cycle immediately after the active burst's last_o (no bubble); ready_o SHALL rise in that same cycle.
REQ-020 SHALL accept a request in the cycle last_o is high; if the slot was empty it SHALL start with no bubble.
REQ-021 SHALL use states IDLE and RUN: IDLE->RUN on accept; RUN->RUN on last with pending or simultaneous accept; RUN->IDLE on last with none; any state->IDLE on abort_i.
REQ-022 SHALL, on abort_i, drop addr_valid_o, last_o and busy_o low from the next cycle, discard the pending slot, and never assert last_o for the aborted burst.
REQ-023 SHALL drive busy_o = (state == RUN) || pending slot occupied.
REQ-024 SHALL register every output except ready_o, and SHALL close timing at 500 MHz; the address/length counters MAY be built from a DSP48E2 in TWO24 mode.

Reset
REQ-025 SHALL, while rstn_i is low, force IDLE, empty the pending slot, set addr_o=0, and hold addr_valid_o, last_o, busy_o, err_o at 0 and ready_o at 1.
REQ-026 SHALL, on reset mid-burst, abandon the burst and pending request without any last_o, and resume accepting requests on the first edge after release.

Verification
REQ-027 Bench SHALL cover: idle, DEPTH=16384, start=100, len=4 -> addresses 100,101,102,103 on cycles +1..+4, last_o on 103, busy_o low at +5.
REQ-028 Bench SHALL cover: DEPTH=1000, start=998, len=4 -> addresses 998,999,0,1, last_o on 1.
REQ-029 Bench SHALL cover: back-to-back, start=10 len=3 then start=50 len=2 queued mid-burst -> 10,11,12,50,51 contiguous, ready_o low from queue until the cycle after 12.
REQ-030 Bench SHALL cover: len=0, LEN_BITS=8 -> 256 addresses, last_o only on the 256th; len=1 -> single address with last_o.
REQ-031 Bench SHALL cover: abort_i on the 2nd address with a request pending -> no further valid addresses, no last_o, busy_o low next cycle, ready_o high once abort_i drops.
REQ-032 Bench SHALL cover: start=DEPTH -> err_o pulse 1 cycle, no addr_valid_o; rstn_i low mid-burst -> all outputs at reset values asynchronously.
